op_dispatcher: RTL and testbench
================================

Name: op_dispatcher

Overview:
- Issuing end of the processor op handshake: buffers decoded ops from the upstream parser and drives `op`/`trigger` into the processor, consuming its `rdy`/`done`.
- Holds each issued op stable on `proc_op` until the processor signals `done`, as the position keeper and handlers require.
- Sits between the G-code decode stage and ProcessorTop, and reports progress and fault status to the top level.

Parameters:
- DEPTH, 4: op buffer entries; power of two, at least 2.
- CNT_BITS, 16: width of the issued-op counter.
- TIMEOUT_CYCLES, 2^20: clk_en-qualified cycles allowed in WAIT_DONE; used only with OP_DISPATCH_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- clk_en  in  1  clock enable; all state updates are qualified by it.
- op_in  in  Op_st  op from the decoder.
- op_in_valid  in  1  op_in is valid.
- op_in_rdy  out  1  buffer can accept an op.
- proc_op  out  Op_st  op presented to the processor.
- proc_trigger  out  1  one-enable-cycle start pulse.
- proc_rdy  in  1  processor idle.
- proc_done  in  1  processor finished the current op.
- busy  out  1  an op is in flight or the buffer is non-empty.
- ops_done_cnt  out  CNT_BITS  completed-op count.
- timeout_err  out  1  sticky watchdog flag (driven 0 without the macro).

Behaviour:
- Reset: when `reset==0` at a clk edge (regardless of clk_en):
  - buffer emptied;
  - state = IDLE;
  - proc_op = all zeros;
  - proc_trigger = 0, ops_done_cnt = 0, timeout_err = 0;
  - op_in_rdy = 1 once reset deasserts (reads 0 during reset), busy = 0.
  - A reset mid-operation abandons the in-flight op. The processor is reset by the same signal.
- Upstream push:
  - op_in_rdy = !full (combinational).
  - A push occurs on a clk edge with clk_en && op_in_valid && op_in_rdy.
  - No bypass: when full, a push is refused even if a pop happens in the same cycle.
  - Push and pop in the same cycle when neither full nor empty: occupancy unchanged.
- State machine: IDLE and WAIT_DONE; transitions only on clk_en edges.
  - IDLE to WAIT_DONE when buffer non-empty && proc_rdy. At that edge:
    - the head entry is popped;
    - proc_op is loaded with the head entry;
    - proc_trigger is set to 1.
  - WAIT_DONE:
    - proc_trigger is cleared on the next clk_en edge, so it is high for exactly one clk_en-qualified cycle.
    - proc_op holds its value.
    - On proc_done, transition to IDLE and increment ops_done_cnt, which wraps at 2^CNT_BITS.
    - proc_done arriving in the same cycle as proc_trigger==1 is accepted.
    - proc_done seen in IDLE is ignored.
  - proc_op keeps the last issued op while in IDLE.
- Latency:
  - Op pushed into an empty buffer with proc_rdy high: proc_trigger is high after the second clk_en edge (one for the buffer write, one for issue).
  - Back-to-back ops: the next trigger comes on the first clk_en edge after done, provided proc_rdy is high.
- busy = (state==WAIT_DONE) || !empty.
- clk_en low freezes every register; proc_trigger stays at its current value.

Optional Feature:
- Macro OP_DISPATCH_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to WAIT_DONE and increments on each clk_en cycle spent in WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES without proc_done: state goes to IDLE, proc_trigger = 0, timeout_err = 1 (sticky until reset), ops_done_cnt is not incremented.
  - Dispatch is then blocked while timeout_err = 1; the buffer still accepts ops until it is full.
- When not defined: no counter exists, timeout_err is tied to 0, and WAIT_DONE waits indefinitely.

Decomposition:
- Package Dispatch_PKG holds:
  - the DispatchState_e enum (IDLE, WAIT_DONE);
  - the default DEPTH, CNT_BITS and TIMEOUT_CYCLES constants.
- Op_st is reused from Op_PKG.
- Sub-module op_fifo:
  - parameterized DEPTH of Op_st entries;
  - signals push, pop, full, empty, head;
  - synchronous active-low reset, clk_en-qualified.

Test Plan:
- Single op (clk_en = 1, proc_rdy = 1):
  - Push op A → proc_trigger pulses one cycle, 2 cycles after the push; proc_op = A stays stable until done.
  - proc_done after 10 cycles → ops_done_cnt = 1, busy = 0.
- Fill to capacity (DEPTH = 4, proc_rdy = 0):
  - Push 5 ops → 4 accepted, op_in_rdy = 0 on the 5th.
  - Raise proc_rdy and answer each trigger with done → ops issued in FIFO order A, B, C, D; ops_done_cnt = 4.
- clk_en = 1 one cycle in 4:
  - proc_trigger is held exactly until the next clk_en edge.
  - proc_done arriving while clk_en = 0 and held to the next clk_en edge → counted once.
- Reset mid-operation:
  - Assert reset low while in WAIT_DONE with 2 ops buffered → next edge: proc_trigger = 0, buffer empty, ops_done_cnt = 0, proc_op = 0.
- Counter wrap:
  - CNT_BITS = 4, 17 completed ops → ops_done_cnt = 1.
- Timeout (macro on, TIMEOUT_CYCLES = 8):
  - No proc_done → timeout_err = 1 after 8 clk_en cycles in WAIT_DONE; state = IDLE; no further trigger even with ops buffered.

Source files
------------

// File: rtl/op_dispatcher_pkg.sv
// Shared types for the op dispatcher: the decoded op record and the dispatcher
// state encoding plus its default sizing constants.
package Op_PKG;
   typedef struct packed {
      logic [3:0]  opcode;
      logic [15:0] arg;
   } Op_st;
endpackage

package Dispatch_PKG;
   typedef enum logic [0:0] {
      IDLE      = 1'b0,
      WAIT_DONE = 1'b1
   } DispatchState_e;

   localparam int DEF_DEPTH          = 4;
   localparam int DEF_CNT_BITS       = 16;
   localparam int DEF_TIMEOUT_CYCLES = 1 << 20;
endpackage

// File: rtl/op_dispatcher_if.sv
// Op handshake bundle: decoder-side push port and processor-side issue port.
// The dispatcher uses the master modport; the decoder/processor side uses slave.
interface op_dispatcher_if;
   import Op_PKG::*;

   Op_st op_in;
   logic op_in_valid;
   logic op_in_rdy;
   Op_st proc_op;
   logic proc_trigger;
   logic proc_rdy;
   logic proc_done;

   modport master (
      input  op_in, op_in_valid, proc_rdy, proc_done,
      output op_in_rdy, proc_op, proc_trigger
   );

   modport slave (
      output op_in, op_in_valid, proc_rdy, proc_done,
      input  op_in_rdy, proc_op, proc_trigger
   );
endinterface

// File: rtl/op_dispatcher_fifo.sv
// op_fifo: DEPTH-entry buffer of decoded ops with registered head; synchronous
// active-low reset, every update qualified by clk_en.
module op_fifo
   import Op_PKG::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clk_en,
   input  logic push,
   input  Op_st push_op,
   input  logic pop,
   output logic full,
   output logic empty,
   output Op_st head
);
   localparam int PTR_W = $clog2(DEPTH);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("op_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [PTR_W:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W:0] rd_ptr_q, rd_ptr_d;
   Op_st           mem_q [DEPTH];
   Op_st           mem_d [DEPTH];
   logic           do_push;
   logic           do_pop;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                  (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
   assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q[PTR_W-1:0]] = push_op;
         wr_ptr_d = wr_ptr_q + (PTR_W + 1)'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + (PTR_W + 1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else if (clk_en) begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (clk_en) begin
         mem_q <= mem_d;
      end
   end
endmodule

// File: rtl/op_dispatcher.sv
// op_dispatcher: buffers decoded ops and issues them one at a time to the processor,
// holding proc_op until done. Optional WAIT_DONE watchdog: OP_DISPATCH_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | no op in flight; issue head entry when buffer non-empty and proc_rdy
// WAIT_DONE | op issued, proc_op held, waiting for proc_done
module op_dispatcher
   import Op_PKG::*;
   import Dispatch_PKG::*;
#(
   parameter int DEPTH          = DEF_DEPTH,
   parameter int CNT_BITS       = DEF_CNT_BITS,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clk_en,
   op_dispatcher_if.master     bus,
   output logic                busy,
   output logic [CNT_BITS-1:0] ops_done_cnt,
   output logic                timeout_err
);
   if ((CNT_BITS < 1) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
      $error("op_dispatcher: CNT_BITS and TIMEOUT_CYCLES must be at least 1");
   end

   DispatchState_e      state_q, state_d;
   Op_st                proc_op_q, proc_op_d;
   logic                proc_trigger_q, proc_trigger_d;
   logic [CNT_BITS-1:0] ops_done_cnt_q, ops_done_cnt_d;

   logic fifo_full;
   logic fifo_empty;
   Op_st fifo_head;
   logic fifo_push;
   logic fifo_pop;
   logic issue;
   logic timeout_hit;
   logic dispatch_block;

   assign bus.op_in_rdy = reset && !fifo_full;
   assign fifo_push     = clk_en && bus.op_in_valid && bus.op_in_rdy;
   assign fifo_pop      = clk_en && issue;

   op_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clk_en  (clk_en),
      .push    (fifo_push),
      .push_op (bus.op_in),
      .pop     (fifo_pop),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .head    (fifo_head)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q        <= IDLE;
         proc_op_q      <= '0;
         proc_trigger_q <= 1'b0;
         ops_done_cnt_q <= '0;
      end else if (clk_en) begin
         state_q        <= state_d;
         proc_op_q      <= proc_op_d;
         proc_trigger_q <= proc_trigger_d;
         ops_done_cnt_q <= ops_done_cnt_d;
      end
   end

   // proc_done wins over a watchdog expiry landing on the same edge.
   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && bus.proc_rdy && !dispatch_block) begin
               state_d = WAIT_DONE;
               issue   = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (bus.proc_done || timeout_hit) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      proc_op_d      = proc_op_q;
      proc_trigger_d = proc_trigger_q;
      ops_done_cnt_d = ops_done_cnt_q;
      if (issue) begin
         proc_op_d      = fifo_head;
         proc_trigger_d = 1'b1;
      end else if (state_q == WAIT_DONE) begin
         proc_trigger_d = 1'b0;
         if (bus.proc_done) begin
            ops_done_cnt_d = ops_done_cnt_q + CNT_BITS'(1);
         end
      end
   end

`ifdef OP_DISPATCH_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic            timeout_err_q, timeout_err_d;

   // Down-counter loaded on issue; reaching zero in WAIT_DONE means TIMEOUT_CYCLES elapsed.
   assign timeout_hit    = (state_q == WAIT_DONE) && (to_cnt_q == '0);
   assign dispatch_block = timeout_err_q;

   always_comb begin
      to_cnt_d      = to_cnt_q;
      timeout_err_d = timeout_err_q;
      if (issue) begin
         to_cnt_d = TO_W'(TIMEOUT_CYCLES - 1);
      end else if ((state_q == WAIT_DONE) && !bus.proc_done) begin
         if (timeout_hit) begin
            timeout_err_d = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q - TO_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         to_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else if (clk_en) begin
         to_cnt_q      <= to_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_hit    = 1'b0;
   assign dispatch_block = 1'b0;
   assign timeout_err    = 1'b0;
`endif

   assign bus.proc_op      = proc_op_q;
   assign bus.proc_trigger = proc_trigger_q;
   assign ops_done_cnt     = ops_done_cnt_q;
   assign busy             = (state_q == WAIT_DONE) || !fifo_empty;
endmodule

// File: tb/tb_op_dispatcher.sv
// Directed bench for op_dispatcher: per-cycle vector table plus hand-written
// sequences; a second instance with CNT_BITS=4 shares the stimulus for wrap checks.
module tb_op_dispatcher;
   import Op_PKG::*;

   logic clk;
   logic reset;
   logic clk_en;
   Op_st op_in;
   logic op_in_valid;
   logic proc_rdy;
   logic proc_done;

   logic        busy_m, busy_w;
   logic [15:0] cnt_m;
   logic [3:0]  cnt_w;
   logic        terr_m, terr_w;

   int n_chk;
   int n_fail;

   op_dispatcher_if bus_m ();
   op_dispatcher_if bus_w ();

   assign bus_m.op_in       = op_in;
   assign bus_m.op_in_valid = op_in_valid;
   assign bus_m.proc_rdy    = proc_rdy;
   assign bus_m.proc_done   = proc_done;
   assign bus_w.op_in       = op_in;
   assign bus_w.op_in_valid = op_in_valid;
   assign bus_w.proc_rdy    = proc_rdy;
   assign bus_w.proc_done   = proc_done;

   op_dispatcher #(
      .DEPTH          (4),
      .CNT_BITS       (16),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .clk_en       (clk_en),
      .bus          (bus_m),
      .busy         (busy_m),
      .ops_done_cnt (cnt_m),
      .timeout_err  (terr_m)
   );

   op_dispatcher #(
      .DEPTH          (4),
      .CNT_BITS       (4),
      .TIMEOUT_CYCLES (8)
   ) dut_w (
      .clk          (clk),
      .reset        (reset),
      .clk_en       (clk_en),
      .bus          (bus_w),
      .busy         (busy_w),
      .ops_done_cnt (cnt_w),
      .timeout_err  (terr_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1, "time limit");
   end

   typedef struct {
      logic        en;
      logic        vld;
      Op_st        op;
      logic        rdy;
      logic        done;
      logic        e_in_rdy;
      logic        e_trig;
      logic        e_busy;
      Op_st        e_op;
      logic [15:0] e_cnt;
   } vec_t;

   vec_t tbl [21];

   function automatic Op_st mk(input int i);
      Op_st o;
      o.opcode = 4'(i);
      o.arg    = 16'hA000 + 16'(i);
      return o;
   endfunction

   function automatic vec_t v(input logic vld, input Op_st op, input logic rdy, input logic done,
                              input logic e_in_rdy, input logic e_trig, input logic e_busy,
                              input Op_st e_op, input logic [15:0] e_cnt);
      vec_t r;
      r.en = 1'b1; r.vld = vld; r.op = op; r.rdy = rdy; r.done = done;
      r.e_in_rdy = e_in_rdy; r.e_trig = e_trig; r.e_busy = e_busy;
      r.e_op = e_op; r.e_cnt = e_cnt;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   Op_st op_a, op_b, op_c, op_d, op_e, op_f, op_z;

   initial begin
      n_chk = 0;
      n_fail = 0;
      op_a = mk(1); op_b = mk(2); op_c = mk(3); op_d = mk(4); op_e = mk(5); op_f = mk(6);
      op_z = '0;

      //          vld op    rdy done | in_rdy trig busy proc_op cnt
      tbl[0]  = v(1, op_b, 0, 0,   1, 0, 1, op_a, 1);
      tbl[1]  = v(1, op_c, 0, 0,   1, 0, 1, op_a, 1);
      tbl[2]  = v(1, op_d, 0, 0,   1, 0, 1, op_a, 1);
      tbl[3]  = v(1, op_e, 0, 0,   0, 0, 1, op_a, 1);
      tbl[4]  = v(1, op_f, 0, 0,   0, 0, 1, op_a, 1);
      tbl[5]  = v(0, op_z, 1, 0,   1, 1, 1, op_b, 1);
      tbl[6]  = v(0, op_z, 1, 1,   1, 0, 1, op_b, 2);
      tbl[7]  = v(0, op_z, 1, 0,   1, 1, 1, op_c, 2);
      tbl[8]  = v(0, op_z, 1, 0,   1, 0, 1, op_c, 2);
      tbl[9]  = v(0, op_z, 1, 1,   1, 0, 1, op_c, 3);
      tbl[10] = v(0, op_z, 0, 0,   1, 0, 1, op_c, 3);
      tbl[11] = v(0, op_z, 1, 0,   1, 1, 1, op_d, 3);
      tbl[12] = v(0, op_z, 1, 1,   1, 0, 1, op_d, 4);
      tbl[13] = v(0, op_z, 1, 0,   1, 1, 1, op_e, 4);
      tbl[14] = v(0, op_z, 1, 1,   1, 0, 0, op_e, 5);
      tbl[15] = v(0, op_z, 1, 1,   1, 0, 0, op_e, 5);
      tbl[16] = v(1, op_f, 0, 0,   1, 0, 1, op_e, 5);
      tbl[17] = v(1, op_a, 1, 0,   1, 1, 1, op_f, 5);
      tbl[18] = v(0, op_z, 1, 1,   1, 0, 1, op_f, 6);
      tbl[19] = v(0, op_z, 1, 0,   1, 1, 1, op_a, 6);
      tbl[20] = v(0, op_z, 1, 1,   1, 0, 0, op_a, 7);

      // Reset applies even with clk_en low.
      reset = 1'b0; clk_en = 1'b0; op_in = '0; op_in_valid = 1'b0; proc_rdy = 1'b0; proc_done = 1'b0;
      step();
      step();
      chk("rst.in_rdy", 32'(bus_m.op_in_rdy), 0);
      chk("rst.trig", 32'(bus_m.proc_trigger), 0);
      chk("rst.busy", 32'(busy_m), 0);
      chk("rst.cnt", 32'(cnt_m), 0);
      chk("rst.proc_op", 32'(bus_m.proc_op), 0);
      chk("rst.terr", 32'(terr_m), 0);
      reset = 1'b1; clk_en = 1'b1;
      #1;
      chk("rst.in_rdy_rel", 32'(bus_m.op_in_rdy), 1);

      // Single op: trigger after the second edge, op held until done.
      op_in = op_a; op_in_valid = 1'b1; proc_rdy = 1'b1;
      step();
      chk("single.trig_e1", 32'(bus_m.proc_trigger), 0);
      chk("single.busy_e1", 32'(busy_m), 1);
      op_in_valid = 1'b0;
      step();
      chk("single.trig_e2", 32'(bus_m.proc_trigger), 1);
      chk("single.op_e2", 32'(bus_m.proc_op), 32'(op_a));
      for (int k = 0; k < 9; k++) begin
         step();
         chk($sformatf("single.trig_hold%0d", k), 32'(bus_m.proc_trigger), 0);
         chk($sformatf("single.op_hold%0d", k), 32'(bus_m.proc_op), 32'(op_a));
      end
      proc_done = 1'b1;
      step();
      proc_done = 1'b0; proc_rdy = 1'b0;
      chk("single.cnt", 32'(cnt_m), 1);
      chk("single.busy", 32'(busy_m), 0);

      // Fill, refuse on full, drain in order, same-cycle push/pop.
      for (int i = 0; i < 21; i++) begin
         clk_en = tbl[i].en; op_in_valid = tbl[i].vld; op_in = tbl[i].op;
         proc_rdy = tbl[i].rdy; proc_done = tbl[i].done;
         step();
         chk($sformatf("v%0d.in_rdy", i), 32'(bus_m.op_in_rdy), 32'(tbl[i].e_in_rdy));
         chk($sformatf("v%0d.trig", i), 32'(bus_m.proc_trigger), 32'(tbl[i].e_trig));
         chk($sformatf("v%0d.busy", i), 32'(busy_m), 32'(tbl[i].e_busy));
         chk($sformatf("v%0d.proc_op", i), 32'(bus_m.proc_op), 32'(tbl[i].e_op));
         chk($sformatf("v%0d.cnt", i), 32'(cnt_m), 32'(tbl[i].e_cnt));
         chk($sformatf("v%0d.cnt_w", i), 32'(cnt_w), 32'(tbl[i].e_cnt[3:0]));
      end
      op_in_valid = 1'b0; proc_done = 1'b0;

      // clk_en one cycle in four.
      clk_en = 1'b0; op_in_valid = 1'b1; op_in = op_b; proc_rdy = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("en.frozen_busy%0d", k), 32'(busy_m), 0);
      end
      clk_en = 1'b1;
      step();
      chk("en.push_busy", 32'(busy_m), 1);
      chk("en.push_trig", 32'(bus_m.proc_trigger), 0);
      clk_en = 1'b0; op_in_valid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk($sformatf("en.pre_trig%0d", k), 32'(bus_m.proc_trigger), 0);
      end
      clk_en = 1'b1;
      step();
      chk("en.issue_trig", 32'(bus_m.proc_trigger), 1);
      chk("en.issue_op", 32'(bus_m.proc_op), 32'(op_b));
      clk_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         if (k == 0) proc_done = 1'b1;
         chk($sformatf("en.trig_held%0d", k), 32'(bus_m.proc_trigger), 1);
      end
      clk_en = 1'b1;
      step();
      chk("en.done_cnt", 32'(cnt_m), 8);
      chk("en.done_trig", 32'(bus_m.proc_trigger), 0);
      chk("en.done_busy", 32'(busy_m), 0);
      clk_en = 1'b0;
      for (int k = 0; k < 3; k++) step();
      clk_en = 1'b1;
      step();
      chk("en.done_once", 32'(cnt_m), 8);
      chk("en.done_once_w", 32'(cnt_w), 8);
      proc_done = 1'b0;

      // Reset mid-operation with two ops buffered.
      proc_rdy = 1'b1; op_in_valid = 1'b1; op_in = op_c;
      step();
      op_in = op_d;
      step();
      chk("mid.trig", 32'(bus_m.proc_trigger), 1);
      chk("mid.op", 32'(bus_m.proc_op), 32'(op_c));
      op_in = op_e;
      step();
      op_in_valid = 1'b0;
      chk("mid.busy", 32'(busy_m), 1);
      reset = 1'b0; clk_en = 1'b0;
      step();
      chk("mid.rst_trig", 32'(bus_m.proc_trigger), 0);
      chk("mid.rst_busy", 32'(busy_m), 0);
      chk("mid.rst_cnt", 32'(cnt_m), 0);
      chk("mid.rst_op", 32'(bus_m.proc_op), 0);
      chk("mid.rst_in_rdy", 32'(bus_m.op_in_rdy), 0);
      reset = 1'b1; clk_en = 1'b1;
      step();
      chk("mid.post_busy", 32'(busy_m), 0);
      chk("mid.post_trig", 32'(bus_m.proc_trigger), 0);

      // 17 completed ops: wraps the 4-bit counter to 1.
      for (int i = 0; i < 17; i++) begin
         op_in = mk(i + 1); op_in_valid = 1'b1;
         step();
         op_in_valid = 1'b0;
         step();
         proc_done = 1'b1;
         step();
         proc_done = 1'b0;
         if (i == 15) chk("wrap.cnt_w16", 32'(cnt_w), 0);
      end
      chk("wrap.cnt", 32'(cnt_m), 17);
      chk("wrap.cnt_w", 32'(cnt_w), 1);
      chk("wrap.busy", 32'(busy_m), 0);

`ifdef OP_DISPATCH_TIMEOUT_EN
      op_in = op_a; op_in_valid = 1'b1;
      step();
      op_in = op_b;
      step();
      op_in_valid = 1'b0;
      for (int k = 0; k < 7; k++) step();
      chk("to.err_before", 32'(terr_m), 0);
      chk("to.busy_before", 32'(busy_m), 1);
      step();
      chk("to.err", 32'(terr_m), 1);
      chk("to.err_w", 32'(terr_w), 1);
      chk("to.cnt", 32'(cnt_m), 17);
      for (int k = 0; k < 4; k++) begin
         step();
         chk($sformatf("to.no_trig%0d", k), 32'(bus_m.proc_trigger), 0);
         chk($sformatf("to.op_kept%0d", k), 32'(bus_m.proc_op), 32'(op_a));
         chk($sformatf("to.busy%0d", k), 32'(busy_m), 1);
      end
`else
      chk("terr.tied", 32'(terr_m), 0);
      chk("terr.tied_w", 32'(terr_w), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
